pattern_serializer: RTL and testbench
=====================================

Name: pattern_serializer

Overview:
- Upstream stimulus stage for the 0000/1111 sequence detector FSM.
- Captures a parallel pattern from switches and presents it as the serial w stream, one bit per debounced step event.
- Lets a user replay a known bit sequence into the detector without toggling SW1 by hand.
- Its w output drives the detector's w input directly; both blocks share the same clock.

Parameters:
- WIDTH, 8, pattern length in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH), width of the bit index counter; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- load  input  1  synchronous, level-sampled; 1 captures pattern and (re)starts shifting.
- pattern  input  WIDTH  parallel pattern; sampled only when load=1.
- step  input  1  advance request, level from a pushbutton; rising edge detected internally.
- repeat  input  1  1: loop the pattern continuously; 0: stop after the last bit.
- w  output  1  current serial bit for the downstream detector.
- w_valid  output  1  1 while w carries a pattern bit.
- busy  output  1  1 in SHIFT.
- done  output  1  1 in DONE; pattern fully emitted.
- bit_idx  output  CNT_W  index of the bit currently on w (0 = first bit sent).

Behaviour:
- Reset (resetn=0, asynchronous, any state):
  - state=IDLE; shift register=0; held copy=0; bit_idx=0; step_q=0.
  - Outputs: w=0, w_valid=0, busy=0, done=0.
  - Deassertion takes effect at the next rising clock.
- States are IDLE, SHIFT and DONE; all outputs are registered or decoded from registered state.
- Step event: step_evt = step & ~step_q, where step_q is step delayed one clock. Holding step high yields exactly one event.
- IDLE:
  - load=1: shreg<=pattern, hold<=pattern, bit_idx<=0, go to SHIFT.
  - step_evt is ignored.
- SHIFT:
  - w = shreg[WIDTH-1] (MSB first); w_valid=1; busy=1.
  - First bit is visible the cycle after load; latency from load to first valid w is 1 clock.
  - step_evt with bit_idx<WIDTH-1: shreg<=shreg<<1, bit_idx<=bit_idx+1.
  - step_evt with bit_idx=WIDTH-1 and repeat=1: shreg<=hold, bit_idx<=0, stay in SHIFT (wrap-around; no gap cycle).
  - step_evt with bit_idx=WIDTH-1 and repeat=0: go to DONE.
- DONE:
  - w=0, w_valid=0, busy=0, done=1; bit_idx holds WIDTH-1.
  - load=1 restarts exactly as from IDLE; step_evt is ignored.
- Priority: load > step_evt in every state. Simultaneous load and step_evt means capture the new pattern with bit_idx=0; the step is discarded.
- repeat is sampled only at the last-bit step event; changing it mid-pattern has no effect until then.
- pattern changes while not loading have no effect (the held copy is used for repeats).
- A reset mid-SHIFT aborts immediately; no partial bit is emitted after resetn returns high.

Optional Feature:
- SERIAL_LSB_FIRST_EN defined:
  - w = shreg[0]; shifts are right shifts.
  - The pattern is emitted LSB first; bit_idx still counts emitted bits from 0.
- Not defined: MSB first as described above.
- All handshake, state and timing behaviour is identical in both builds.

Decomposition:
- Shared package pattern_serializer_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- One sub-module, rise_edge_detect:
  - Ports clock, resetn, in, pulse.
  - Registered delay with asynchronous active-low reset; pulse = in & ~in_q.
  - Reused for the step input.

Test Plan:
- Basic emission: WIDTH=8, load with pattern=8'hF0, repeat=0, then 8 step pulses.
  - w reads 1,1,1,1,0,0,0,0 with w_valid=1 and bit_idx 0..7.
  - After the 8th step: done=1, w_valid=0, w=0.
- Held step: after loading 8'hAA, hold step high for 6 clocks.
  - Exactly one advance: bit_idx goes 0->1 and w goes 1->0, then holds.
- Repeat wrap: load 8'h0F, repeat=1, 9 step pulses.
  - After step 8: bit_idx=0, w=0 (MSB of 8'h0F) in the same cycle, busy=1, done=0.
  - After step 9: bit_idx=1.
- Load priority: in SHIFT at bit_idx=3, assert load with pattern=8'h80 in the same cycle as step_evt.
  - Next cycle: bit_idx=0, w=1.
  - Next step: w=0.
- Async reset: pull resetn low mid-cycle in SHIFT at bit_idx=5.
  - w, w_valid, busy, done and bit_idx all read 0 before the next clock edge.
  - After release, state is IDLE and step pulses are ignored.
- Optional-feature build with SERIAL_LSB_FIRST_EN: load 8'h01, repeat=0, 8 steps.
  - w reads 1,0,0,0,0,0,0,0.
  - done=1 after the 8th step.

Source files
------------

// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer: FSM state encoding and
// the default pattern length.
package pattern_serializer_pkg;

  // Default pattern length in bits (legal range 2..16).
  localparam int DEFAULT_WIDTH = 8;

  // FSM state encoding; 2'd3 is unused and forces a return to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle rising-edge pulse generator for a level input.
// A held-high input produces exactly one pulse.
module rise_edge_detect (
  input  logic clock,
  input  logic resetn,
  input  logic in,
  output logic pulse
);

  logic r_in_q;

  // Delay the input by one clock so the edge can be seen.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_in_q <= 1'b0;
    end else begin
      r_in_q <= in;
    end
  end

  assign pulse = in & ~r_in_q;

endmodule

// File: rtl/pattern_serializer.sv
// Pattern serializer: captures a parallel pattern on load and emits it one
// bit per step rising edge on w, either once or looping on repeat_mode.
// The SV keyword "repeat" cannot be a port name, so that input is
// repeat_mode.
// Optional build macro: SERIAL_LSB_FIRST_EN -- emit the pattern LSB first
// (right shifts) instead of MSB first. Timing and handshakes are unchanged.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             step,
  input  logic             repeat_mode,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_hold;
  logic [CNT_W-1:0]   r_bit_idx;

  state_t             w_state_next;
  logic [WIDTH-1:0]   w_shreg_next;
  logic [WIDTH-1:0]   w_hold_next;
  logic [CNT_W-1:0]   w_idx_next;
  logic               w_step_evt;
  logic               w_head_bit;
  logic [WIDTH-1:0]   w_shifted;

  rise_edge_detect u_step_edge (
    .clock  (clock),
    .resetn (resetn),
    .in     (step),
    .pulse  (w_step_evt)
  );

`ifdef SERIAL_LSB_FIRST_EN
  assign w_head_bit = r_shreg[0];
  assign w_shifted  = r_shreg >> 1;
`else
  assign w_head_bit = r_shreg[WIDTH-1];
  assign w_shifted  = r_shreg << 1;
`endif

  // State, shift register, held copy and bit index registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_hold    <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_hold    <= w_hold_next;
      r_bit_idx <= w_idx_next;
    end
  end

  // Next-state logic; load always wins over a coincident step edge.
  always_comb begin
    w_state_next = r_state;
    w_shreg_next = r_shreg;
    w_hold_next  = r_hold;
    w_idx_next   = r_bit_idx;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          w_shreg_next = pattern;
          w_hold_next  = pattern;
          w_idx_next   = '0;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (load) begin
          w_shreg_next = pattern;
          w_hold_next  = pattern;
          w_idx_next   = '0;
        end else if (w_step_evt) begin
          if (r_bit_idx != LAST_IDX) begin
            w_shreg_next = w_shifted;
            w_idx_next   = r_bit_idx + 1'b1;
          end else if (repeat_mode) begin
            // Wrap straight back to the first bit with no gap cycle.
            w_shreg_next = r_hold;
            w_idx_next   = '0;
          end else begin
            // bit_idx deliberately stays at the last index in DONE.
            w_state_next = ST_DONE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy    = (r_state == ST_SHIFT);
    w_valid = (r_state == ST_SHIFT);
    done    = (r_state == ST_DONE);
    w       = (r_state == ST_SHIFT) & w_head_bit;
    bit_idx = r_bit_idx;
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: the driver updates a behavioural
// model (held pattern + emit position) each clock and queues the expected
// outputs; an independent monitor pops and compares after every edge.
module tb_pattern_serializer;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W);
  localparam int M_IDLE  = 0;
  localparam int M_SHIFT = 1;
  localparam int M_DONE  = 2;

  typedef struct packed {
    logic             w;
    logic             v;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] idx;
  } obs_t;

  logic             clk;
  logic             resetn;
  logic             load;
  logic [W-1:0]     pattern;
  logic             step;
  logic             repeat_mode;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_idx;

  int n_cmp;
  int n_err;

  obs_t exp_q[$];

  // Reference model state
  int           m_mode;
  int           m_pos;
  logic [W-1:0] m_seq;
  logic         m_prev_step;

  pattern_serializer #(.WIDTH(W)) dut (
    .clock       (clk),
    .resetn      (resetn),
    .load        (load),
    .pattern     (pattern),
    .step        (step),
    .repeat_mode (repeat_mode),
    .w           (w),
    .w_valid     (w_valid),
    .busy        (busy),
    .done        (done),
    .bit_idx     (bit_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k-th emitted bit of a pattern, in emission order.
  function automatic logic emit_bit(input logic [W-1:0] p, input int k);
`ifdef SERIAL_LSB_FIRST_EN
    return p[k];
`else
    return p[W-1-k];
`endif
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.v    = (m_mode == M_SHIFT);
    o.busy = (m_mode == M_SHIFT);
    o.done = (m_mode == M_DONE);
    o.w    = (m_mode == M_SHIFT) ? emit_bit(m_seq, m_pos) : 1'b0;
    o.idx  = CNT_W'(m_pos);
    return o;
  endfunction

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_pos       = 0;
    m_seq       = '0;
    m_prev_step = 1'b0;
  endtask

  // Drive one clock worth of inputs and queue what the DUT must show after it.
  task automatic cycle(input logic ld, input logic [W-1:0] pat,
                       input logic st, input logic rp);
    logic evt;
    @(negedge clk);
    load        = ld;
    pattern     = pat;
    step        = st;
    repeat_mode = rp;
    evt         = st & ~m_prev_step;
    m_prev_step = st;
    if (ld) begin
      m_seq  = pat;
      m_pos  = 0;
      m_mode = M_SHIFT;
      $display("TXN t=%0t load pattern=%h repeat=%b step=%b", $time, pat, rp, st);
    end else if (evt && m_mode == M_SHIFT) begin
      if (m_pos < W - 1) m_pos = m_pos + 1;
      else if (rp) m_pos = 0;
      else m_mode = M_DONE;
      $display("TXN t=%0t step -> pos=%0d mode=%0d", $time, m_pos, m_mode);
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic pulse(input logic rp);
    cycle(1'b0, W'($urandom), 1'b1, rp);
    cycle(1'b0, W'($urandom), 1'b0, rp);
  endtask

  task automatic check_zero_outputs(input string name);
    n_cmp++;
    if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bit_idx !== '0) begin
      n_err++;
      $display("FAIL %s: got w=%b w_valid=%b busy=%b done=%b bit_idx=%0d, required all 0",
               name, w, w_valid, busy, done, bit_idx);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{w: w, v: w_valid, busy: busy, done: done, idx: bit_idx};
        n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t: got w=%b v=%b busy=%b done=%b idx=%0d, required w=%b v=%b busy=%b done=%b idx=%0d",
                   $time, g.w, g.v, g.busy, g.done, g.idx,
                   e.w, e.v, e.busy, e.done, e.idx);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic st;
    logic rp;
    n_cmp       = 0;
    n_err       = 0;
    resetn      = 1'b0;
    load        = 1'b0;
    pattern     = '0;
    step        = 1'b0;
    repeat_mode = 1'b0;
    model_reset();
    #2;
    check_zero_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Basic emission, once through
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pulse(1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Held step gives one advance only
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Repeat wrap-around
    cycle(1'b1, 8'h0F, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) pulse(1'b1);

    // Load beats a coincident step edge
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    cycle(1'b1, 8'h80, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    pulse(1'b0);

    // Reload from DONE
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pulse(1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    pulse(1'b0);

    // Asynchronous reset mid-SHIFT at bit_idx 5
    cycle(1'b1, 8'hB7, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) pulse(1'b1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    load        = 1'b0;
    step        = 1'b0;
    repeat_mode = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) pulse(1'b0);

    // Randomized traffic
    st = 1'b0;
    rp = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) st = ~st;
      if ($urandom_range(0, 30) == 0) rp = ~rp;
      cycle(($urandom_range(0, 39) == 0), W'($urandom), st, rp);
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
